// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a time,
// holds the returned instruction for decode, and discards responses made stale by redirects.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_o_valid,
  input  logic        fetch_o_ready,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  output logic [63:0] fetch_o_pre_pc,
  output logic [31:0] fetch_o_drop_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_reg;
  logic [63:0] pc_reg;
  logic [63:0] out_pc_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] drop_cnt_reg;
  logic        req_valid_reg;
  logic        out_valid_reg;
  logic [63:0] redirect_aligned;

  // Low two bits of a redirect target are forced to zero so every request is word aligned.
  assign redirect_aligned = redirect_pc & ~64'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      out_pc_reg    <= 64'd0;
      out_instr_reg <= 32'd0;
      drop_cnt_reg  <= 32'd0;
      req_valid_reg <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem_req_ready) begin
            req_valid_reg <= 1'b0;
            if (redirect_valid) begin
              pc_reg    <= redirect_aligned;
              state_reg <= S_DROP;
            end else begin
              state_reg <= S_WAIT;
            end
          end else if (redirect_valid) begin
            pc_reg <= redirect_aligned;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_reg <= redirect_aligned;
            if (imem_resp_valid) begin
              drop_cnt_reg  <= drop_cnt_reg + 32'd1;
              state_reg     <= S_REQ;
              req_valid_reg <= 1'b1;
            end else begin
              state_reg <= S_DROP;
            end
          end else if (imem_resp_valid) begin
            out_pc_reg    <= pc_reg;
            out_instr_reg <= imem_resp_data;
            state_reg     <= S_HOLD;
            out_valid_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          // A redirect overrides the sequential next PC even when decode accepts.
          if (redirect_valid || fetch_o_ready) begin
            pc_reg        <= redirect_valid ? redirect_aligned : pc_reg + 64'd4;
            state_reg     <= S_REQ;
            req_valid_reg <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        S_DROP: begin
          if (redirect_valid) begin
            pc_reg <= redirect_aligned;
          end
          if (imem_resp_valid) begin
            drop_cnt_reg  <= drop_cnt_reg + 32'd1;
            state_reg     <= S_REQ;
            req_valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= S_REQ;
          req_valid_reg <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid   = req_valid_reg;
  assign imem_req_addr    = pc_reg;
  assign fetch_o_valid    = out_valid_reg;
  assign fetch_o_pc       = out_pc_reg;
  assign fetch_o_instr    = out_instr_reg;
  assign fetch_o_pre_pc   = out_pc_reg + 64'd4;
  assign fetch_o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: bench-driven memory and decode, with a scoreboard of
// expected (pc, instr) pairs pushed at request acceptance and popped when decode sees them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fetch_o_valid;
  logic        fetch_o_ready;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic [63:0] fetch_o_pre_pc;
  logic [31:0] fetch_o_drop_cnt;

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .fetch_o_valid    (fetch_o_valid),
    .fetch_o_ready    (fetch_o_ready),
    .fetch_o_pc       (fetch_o_pc),
    .fetch_o_instr    (fetch_o_instr),
    .fetch_o_pre_pc   (fetch_o_pre_pc),
    .fetch_o_drop_cnt (fetch_o_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_pc;
  logic [31:0] pend_instr;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;
  int          req_cyc;
  int          prev_req_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request at exp_pc, optionally stall it, then accept it.
  task automatic issue(input logic [31:0] instr, input int stall);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("req_addr", imem_req_addr, exp_pc);
    prev_req_cyc = req_cyc;
    req_cyc = cyc;
    imem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("stall_addr", imem_req_addr, exp_pc);
    end
    imem_req_ready = 1'b1;
    sb.push_back('{exp_pc, instr});
    pend_instr = instr;
    tick();
    imem_req_ready = 1'b0;
    chk("one_outstanding", {63'd0, imem_req_valid}, 64'd0);
    $display("req  addr=%h instr=%h stall=%0d cyc=%0d", exp_pc, instr, stall, req_cyc);
  endtask

  // Return the pending instruction and compare the held output against the scoreboard.
  task automatic respond();
    sb_t ent;
    imem_resp_valid = 1'b1;
    imem_resp_data  = pend_instr;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    chk("sb_empty", {63'd0, sb.size() == 0}, 64'd0);
    ent = (sb.size() > 0) ? sb.pop_front() : '{64'd0, 32'd0};
    chk("hold_valid", {63'd0, fetch_o_valid}, 64'd1);
    chk("hold_pc", fetch_o_pc, ent.pc);
    chk("hold_instr", {32'd0, fetch_o_instr}, {32'd0, ent.instr});
    chk("hold_pre_pc", fetch_o_pre_pc, ent.pc + 64'd4);
    hold_pc    = ent.pc;
    hold_instr = ent.instr;
    $display("hold pc=%h instr=%h pre_pc=%h", fetch_o_pc, fetch_o_instr, fetch_o_pre_pc);
  endtask

  // Let decode stall for dstall cycles, then accept, optionally with a redirect.
  task automatic consume(input int dstall, input logic redir, input logic [63:0] rpc);
    for (int i = 0; i < dstall; i++) begin
      fetch_o_ready = 1'b0;
      tick();
      chk("dstall_valid", {63'd0, fetch_o_valid}, 64'd1);
      chk("dstall_pc", fetch_o_pc, hold_pc);
      chk("dstall_instr", {32'd0, fetch_o_instr}, {32'd0, hold_instr});
      chk("dstall_noreq", {63'd0, imem_req_valid}, 64'd0);
    end
    fetch_o_ready  = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    tick();
    fetch_o_ready  = 1'b0;
    redirect_valid = 1'b0;
    exp_pc = redir ? (rpc & ~64'h3) : (exp_pc + 64'd4);
    chk("consumed_valid", {63'd0, fetch_o_valid}, 64'd0);
    $display("take pc=%h dstall=%0d redirect=%0d next=%h", hold_pc, dstall, redir, exp_pc);
  endtask

  initial begin
    sb_t dropped;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    fetch_o_ready   = 1'b0;
    req_cyc         = 0;
    prev_req_cyc    = 0;
    tick();
    tick();
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("rst_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
    chk("rst_out_valid", {63'd0, fetch_o_valid}, 64'd0);
    chk("rst_out_pc", fetch_o_pc, 64'd0);
    chk("rst_out_instr", {32'd0, fetch_o_instr}, 64'd0);
    chk("rst_pre_pc", fetch_o_pre_pc, 64'd4);
    chk("rst_drop_cnt", {32'd0, fetch_o_drop_cnt}, 64'd0);
    $display("reset released");
    rst    = 1'b0;
    exp_pc = 64'h0000_0000_8000_0000;

    // Zero-wait streaming: one instruction every 3 cycles, 2-cycle latency.
    issue(32'h0000_0013, 0);
    respond();
    chk("latency", 64'(cyc - req_cyc), 64'd2);
    consume(0, 1'b0, 64'd0);
    issue(32'h0010_0093, 0);
    chk("spacing1", 64'(req_cyc - prev_req_cyc), 64'd3);
    respond();
    consume(0, 1'b0, 64'd0);
    issue(32'h0020_0113, 0);
    chk("spacing2", 64'(req_cyc - prev_req_cyc), 64'd3);
    chk("third_addr", exp_pc, 64'h0000_0000_8000_0008);
    respond();
    consume(0, 1'b0, 64'd0);

    // Memory back-pressure for 4 cycles, accepted on the 5th.
    issue(32'h0030_0193, 4);
    respond();
    consume(0, 1'b0, 64'd0);

    // Decode stall for 5 cycles.
    issue(32'h0040_0213, 0);
    respond();
    consume(5, 1'b0, 64'd0);

    // Response while in REQ is ignored.
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("proto_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("proto_req_addr", imem_req_addr, exp_pc);
    chk("proto_drop_cnt", {32'd0, fetch_o_drop_cnt}, 64'd0);
    chk("proto_out_valid", {63'd0, fetch_o_valid}, 64'd0);
    $display("protocol-error response ignored");

    // Redirect during WAIT, stale response three cycles later.
    issue(32'h0050_0293, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1002;
    tick();
    redirect_valid = 1'b0;
    dropped = sb.pop_front();
    chk("drop_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    chk("drop_wait1_valid", {63'd0, fetch_o_valid}, 64'd0);
    tick();
    chk("drop_wait2_valid", {63'd0, fetch_o_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = dropped.instr;
    tick();
    imem_resp_valid = 1'b0;
    chk("drop_cnt1", {32'd0, fetch_o_drop_cnt}, 64'd1);
    chk("drop_not_fwd", {63'd0, fetch_o_valid}, 64'd0);
    exp_pc = 64'h1000;
    chk("drop_next_addr", imem_req_addr, 64'h1000);
    $display("stale response dropped at %h, drop_cnt=%0d", dropped.pc, fetch_o_drop_cnt);

    // Redirect coinciding with the response in WAIT.
    issue(32'h0060_0313, 0);
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h2000;
    imem_resp_valid = 1'b1;
    imem_resp_data  = pend_instr;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    dropped = sb.pop_front();
    exp_pc  = 64'h2000;
    chk("drop_cnt2", {32'd0, fetch_o_drop_cnt}, 64'd2);
    chk("wait_redir_valid", {63'd0, fetch_o_valid}, 64'd0);
    chk("wait_redir_addr", imem_req_addr, 64'h2000);
    $display("redirect+response in WAIT, drop_cnt=%0d", fetch_o_drop_cnt);

    // Retarget an unaccepted request.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 64'h3000;
    chk("retarget_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("retarget_addr", imem_req_addr, 64'h3000);
    $display("request retargeted to %h", imem_req_addr);

    // Redirect together with decode ready: redirect target wins over pc+4.
    issue(32'h0070_0393, 0);
    respond();
    consume(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);

    // Wrap-around fetch at the top of the address space.
    issue(32'h0080_0413, 0);
    respond();
    chk("wrap_pre_pc", fetch_o_pre_pc, 64'd0);
    consume(0, 1'b0, 64'd0);
    chk("wrap_next", exp_pc, 64'd0);
    issue(32'h0090_0493, 0);
    respond();
    consume(0, 1'b0, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
